// File: rtl/io_uart_periph.sv
// UART peripheral on the processor IO bus: four-port register map, TX/RX FIFOs,
// and 8N1 serialiser/deserialiser with sticky overrun and framing-error flags.

module io_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr, rptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module io_uart_periph #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] BASE_PORT    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_port_id,
  input  logic [7:0] io_write_data,
  input  logic       io_write_strobe,
  input  logic       io_read_strobe,
  output logic [7:0] io_read_data,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_MID = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // bus decode
  logic [7:0] off;
  logic       hit, tx_wr, ctrl_wr, rx_rd, flush;
  assign off     = io_port_id - BASE_PORT;
  assign hit     = (off[7:2] == 6'd0);
  assign tx_wr   = hit && io_write_strobe && (off[1:0] == 2'd0);
  assign ctrl_wr = hit && io_write_strobe && (off[1:0] == 2'd3);
  assign rx_rd   = hit && io_read_strobe  && (off[1:0] == 2'd2);
  assign flush   = ctrl_wr && io_write_data[2];

  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_pop, rx_push;

  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .flush(flush),
    .push(tx_wr), .wdata(io_write_data), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  logic [7:0] rx_shift;
  io_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .flush(flush),
    .push(rx_push), .wdata(rx_shift), .pop(rx_rd),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // TX serialiser
  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_end, tx_line;
  assign tx_end = (tx_cnt == BAUD_END);

  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      IDLE: if (!tx_empty && !flush) begin
        tx_pop     = 1'b1;
        tx_state_n = START;
      end
      START: begin
        tx_line = 1'b0;
        if (tx_end) tx_state_n = DATA;
      end
      DATA: begin
        tx_line = tx_shift[0];
        if (tx_end && tx_bit == 3'd7) tx_state_n = STOP;
      end
      STOP: if (tx_end) begin
        if (!tx_empty && !flush) begin
          tx_pop     = 1'b1;
          tx_state_n = START;
        end else begin
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != IDLE) begin
        tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
        if (tx_state == DATA && tx_end) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end
    end
  end

  assign uart_tx = tx_line;

  // RX synchroniser and deserialiser
  logic          rx_s1, rx_sync, rx_prev;
  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_restart, set_fe, set_ov;
  logic          overrun, frame_err;

  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    set_fe     = 1'b0;
    rx_restart = 1'b0;
    case (rx_state)
      IDLE: if (rx_prev && !rx_sync) rx_state_n = START;
      START: if (rx_cnt == BAUD_MID) begin
        rx_restart = 1'b1;
        rx_state_n = rx_sync ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BAUD_END) begin
        rx_restart = 1'b1;
        if (rx_bit == 3'd7) rx_state_n = STOP;
      end
      STOP: if (rx_cnt == BAUD_END) begin
        rx_restart = 1'b1;
        rx_state_n = IDLE;
        rx_push    = rx_sync;
        set_fe     = !rx_sync;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_sync  <= rx_s1;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= (rx_state == IDLE || rx_restart) ? '0 : rx_cnt + 1'b1;
      if (rx_state == DATA && rx_cnt == BAUD_END) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // a byte arriving into a full FIFO with no same-cycle read is lost
  assign set_ov = rx_push && rx_full && !(rx_rd && !rx_empty) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= set_ov || (overrun   && !(ctrl_wr && io_write_data[0]));
      frame_err <= set_fe || (frame_err && !(ctrl_wr && io_write_data[1]));
    end
  end

  always_comb begin
    io_read_data = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd1: io_read_data = {1'b0, frame_err, (tx_state != IDLE), overrun,
                              rx_full, !rx_empty, tx_empty, tx_full};
        2'd2: io_read_data = rx_empty ? 8'h00 : rx_head;
        default: io_read_data = 8'h00;
      endcase
    end
  end

  assign irq = !rx_empty || overrun || frame_err;
endmodule
